// File: rtl/shreg_pkg.sv
// Shared types and helpers for the divider's multi-mode shift register.
package shreg_pkg;

  typedef enum logic [1:0] {
    SHREG_HOLD = 2'b00,
    SHREG_LOAD = 2'b01,
    SHREG_SHL  = 2'b10,
    SHREG_SHR  = 2'b11
  } shreg_mode_e;

  // Bits needed to hold a count of 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating up-counter with registered at-max flag; clear beats increment.
module shift_counter #(
  parameter int MAX = 16,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          increment,
  output logic [CW-1:0] count,
  output logic          at_max
);

  logic [CW-1:0] count_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(MAX)) ? c : c + 1'b1;
  endfunction

  always_comb begin
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (increment)
      count_nxt = sat_inc(count);
  end

  // at_max is registered from the next count so it lines up with count
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      at_max <= 1'b0;
    end else begin
      count  <= count_nxt;
      at_max <= (count_nxt == CW'(MAX));
    end
  end

endmodule

// File: rtl/shift_register_n.sv
// Multi-mode register (hold/load/shift left/shift right) with a saturating shift counter.
// Build option SHREG_ROTATE_EN: arith=1 in shift-left mode rotates instead of using serial_in.
module shift_register_n
  import shreg_pkg::*;
#(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int             CW          = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] input_data,
  input  logic             serial_in,
  input  logic             arith,
  input  logic             clr_count,
  output logic [WIDTH-1:0] output_data,
  output logic             shift_out,
  output logic [CW-1:0]    shift_count,
  output logic             done
);

  shreg_mode_e      mode_e;
  logic [WIDTH-1:0] data_nxt;
  logic             sout_nxt;
  logic             is_shift;
  logic             cnt_clear;

  assign mode_e    = shreg_mode_e'(mode);
  assign is_shift  = (mode_e == SHREG_SHL) || (mode_e == SHREG_SHR);
  assign cnt_clear = clr_count || (mode_e == SHREG_LOAD);

  always_comb begin
    data_nxt = output_data;
    sout_nxt = shift_out;
    case (mode_e)
      SHREG_LOAD: data_nxt = input_data;
      SHREG_SHL: begin
`ifdef SHREG_ROTATE_EN
        data_nxt = {output_data[WIDTH-2:0], arith ? output_data[WIDTH-1] : serial_in};
`else
        data_nxt = {output_data[WIDTH-2:0], serial_in};
`endif
        sout_nxt = output_data[WIDTH-1];
      end
      SHREG_SHR: begin
        data_nxt = {arith ? output_data[WIDTH-1] : serial_in, output_data[WIDTH-1:1]};
        sout_nxt = output_data[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_data <= RESET_VALUE;
      shift_out   <= 1'b0;
    end else begin
      output_data <= data_nxt;
      shift_out   <= sout_nxt;
    end
  end

  shift_counter #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .increment (is_shift),
    .count     (shift_count),
    .at_max    (done)
  );

endmodule

// File: tb/tb_shift_register_n.sv
// Scoreboard bench for shift_register_n (WIDTH=16, RESET_VALUE=0).
module tb_shift_register_n;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         so;
    logic [4:0]   c;
    logic         dn;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] input_data = '0;
  logic         serial_in = 1'b0;
  logic         arith = 1'b0;
  logic         clr_count = 1'b0;
  logic [W-1:0] output_data;
  logic         shift_out;
  logic [4:0]   shift_count;
  logic         done;

  obs_t obs, e;
  obs_t sb[$];
  obs_t m;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign obs = '{d: output_data, so: shift_out, c: shift_count, dn: done};

  shift_register_n #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk(clk), .rst(rst), .mode(mode), .input_data(input_data),
    .serial_in(serial_in), .arith(arith), .clr_count(clr_count),
    .output_data(output_data), .shift_out(shift_out),
    .shift_count(shift_count), .done(done)
  );

  // Reference model: advance m by one edge, push the expectation, drive the DUT.
  task automatic step(input logic [1:0] md, input logic [W-1:0] din,
                      input logic sin, input logic ar, input logic clr, input logic rs);
    obs_t n;
    n = m;
    if (rs) begin
      n = '0;
    end else begin
      if (md == 2'b01) n.d = din;
      if (md == 2'b10) begin
        n.so = m.d[W-1];
`ifdef SHREG_ROTATE_EN
        n.d = {m.d[W-2:0], ar ? m.d[W-1] : sin};
`else
        n.d = {m.d[W-2:0], sin};
`endif
      end
      if (md == 2'b11) begin
        n.so = m.d[0];
        n.d  = {ar ? m.d[W-1] : sin, m.d[W-1:1]};
      end
      if (clr || md == 2'b01) n.c = 5'd0;
      else if (md[1])         n.c = (m.c == 5'd16) ? 5'd16 : m.c + 5'd1;
      n.dn = (n.c == 5'd16);
    end
    m = n;
    sb.push_back(n);
    mode = md; input_data = din; serial_in = sin; arith = ar; clr_count = clr; rst = rs;
    @(posedge clk);
    #1;
    rst = 1'b0; mode = 2'b00; clr_count = 1'b0;
  endtask

  task automatic test_reset();
    step(2'b10, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset: got %h required %h", obs, e); end
    checks++;
    if (obs !== obs_t'(0)) begin errors++; $display("FAIL reset_zero: got %h required 0", obs); end
  endtask

  task automatic test_load_hold();
    step(2'b01, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL load: got %h required %h", obs, e); end
    checks++;
    if (output_data !== 16'hA5C3 || shift_count !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL load_const: got %h/%0d/%b required a5c3/0/0", output_data, shift_count, done);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hold%0d: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_shift_left();
    step(2'b01, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(2'b10, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL shl: got %h required %h", obs, e); end
    checks++;
    if (output_data !== 16'h0003 || shift_out !== 1'b1 || shift_count !== 5'd1) begin
      errors++; $display("FAIL shl_const: got %h/%b/%0d required 0003/1/1", output_data, shift_out, shift_count);
    end
    step(2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL hold_sout: got %h required %h", obs, e); end
  endtask

  task automatic test_shift_right();
    step(2'b01, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(2'b11, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e || output_data !== 16'hC000 || shift_out !== 1'b0) begin
      errors++; $display("FAIL shr_arith: got %h required %h (data c000)", obs, e);
    end
    step(2'b01, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e || output_data !== 16'h4000 || shift_out !== 1'b1) begin
      errors++; $display("FAIL shr_logic: got %h required %h (data 4000)", obs, e);
    end
  endtask

  task automatic test_counter();
    step(2'b01, 16'h3C5A, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 17; i++) begin
      step({1'b1, 1'($urandom_range(0, 1))}, 16'h0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL count%0d: got %h required %h", i, obs, e); end
    end
    checks++;
    if (shift_count !== 5'd16 || done !== 1'b1) begin
      errors++; $display("FAIL count_sat: got %0d/%b required 16/1", shift_count, done);
    end
    step(2'b01, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e || shift_count !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL count_reload: got %h required %h", obs, e);
    end
  endtask

  task automatic test_reset_mid();
    step(2'b01, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    step(2'b10, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs !== obs_t'(0)) begin
      errors++; $display("FAIL reset_mid: got %h required %h", obs, e);
    end
    step(2'b01, 16'h00F1, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(2'b10, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(2'b10, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e || output_data !== 16'h03C5 || shift_count !== 5'd0) begin
      errors++; $display("FAIL clr_shift: got %h required %h (data 03c5 count 0)", obs, e);
    end
    step(2'b01, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL clr_load: got %h required %h", obs, e); end
  endtask

  task automatic test_rotate();
    logic [W-1:0] want;
`ifdef SHREG_ROTATE_EN
    want = 16'h0003;
`else
    want = 16'h0002;
`endif
    step(2'b01, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(2'b10, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (obs !== e || output_data !== want || shift_out !== 1'b1) begin
      errors++; $display("FAIL rotate: got %h required %h (data %h)", obs, e, want);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b%0d: got %h required %h", i, obs, e); end
    end
  endtask

  initial begin
    m = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_hold();
    test_shift_left();
    test_shift_right();
    test_counter();
    test_reset_mid();
    test_rotate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
